pipe_credit_ctrl: RTL and testbench

PIPE_CREDIT_CTRL -- requirements
Module: pipe_credit_ctrl

---
 rtl/pipe_credit_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_credit_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_credit_ctrl.sv
// Credit-based flow controller for a fixed-depth pipeline feeding an output FIFO.
// Tracks words in flight and words buffered, and gates admission on free credits.
module pipe_credit_ctrl #(
  parameter int STAGE_COUNT = 16,
  parameter int FIFO_DEPTH  = 32,
  parameter int CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          hold,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          pipe_valid_in,
  output logic          pipe_advance,
  input  logic          pipe_valid_out,
  output logic          fifo_wr,
  input  logic          fifo_rd,
  output logic [CW-1:0] inflight,
  output logic [CW-1:0] occupancy,
  output logic [1:0]    state,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // The pipeline latency is never modelled here; only observed valids are counted.
  if (STAGE_COUNT < 1 || FIFO_DEPTH < STAGE_COUNT) begin : g_bad_params
    $error("pipe_credit_ctrl: need STAGE_COUNT >= 1 and FIFO_DEPTH >= STAGE_COUNT");
  end

  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  state_e        state_q, state_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] occupancy_q, occupancy_d;
  logic          err_q, err_d;

  logic [CW:0]   used_w;
  logic          credit_avail;
  logic          admit;
  logic          rd_ok;
  logic          rd_underflow;
  logic          wr_underflow;

  // One spare bit so the sum cannot wrap; a credit exists while used < depth.
  assign used_w       = {1'b0, occupancy_q} + {1'b0, inflight_q};
  assign credit_avail = (used_w < DEPTH_W);

  assign in_ready      = (state_q == S_RUN) && credit_avail;
  assign admit         = in_valid && in_ready;
  assign pipe_valid_in = admit;
  assign pipe_advance  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign fifo_wr       = pipe_valid_out && pipe_advance;

  assign rd_ok        = fifo_rd && (occupancy_q != '0);
  assign rd_underflow = fifo_rd && (occupancy_q == '0);
  assign wr_underflow = fifo_wr && (inflight_q == '0);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN: begin
        if (!enable)   state_d = S_DRAIN;
        else if (hold) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!enable)   state_d = S_DRAIN;
        else if (!hold) state_d = S_RUN;
      end
      S_DRAIN: if (inflight_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (admit && !fifo_wr) begin
      inflight_d = inflight_q + CW'(1);
    end else if (fifo_wr && !admit && !wr_underflow) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  always_comb begin
    occupancy_d = occupancy_q;
    if (fifo_wr && !rd_ok) begin
      occupancy_d = occupancy_q + CW'(1);
    end else if (rd_ok && !fifo_wr) begin
      occupancy_d = occupancy_q - CW'(1);
    end
  end

  assign err_d = err_q || rd_underflow || wr_underflow;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      inflight_q  <= '0;
      occupancy_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      occupancy_q <= occupancy_d;
      err_q       <= err_d;
    end
  end

  assign inflight  = inflight_q;
  assign occupancy = occupancy_q;
  assign state     = state_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pipe_credit_ctrl.sv
// Self-checking bench for pipe_credit_ctrl: a directed vector table plus
// hand-written sequences driven through a behavioural 16-stage pipeline.
module tb_pipe_credit_ctrl;

  localparam int S  = 16;
  localparam int D  = 32;
  localparam int CW = $clog2(D + 1);

  logic          clk;
  logic          reset;
  logic          enable;
  logic          hold;
  logic          in_valid;
  logic          in_ready;
  logic          pipe_valid_in;
  logic          pipe_advance;
  logic          pipe_valid_out;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [CW-1:0] inflight;
  logic [CW-1:0] occupancy;
  logic [1:0]    state;
  logic          err;

  logic          use_model;
  logic          pvo_drv;
  logic [S-1:0]  pipe_sr;

  int checks = 0;
  int errors = 0;

  pipe_credit_ctrl #(.STAGE_COUNT(S), .FIFO_DEPTH(D)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .hold           (hold),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .pipe_valid_in  (pipe_valid_in),
    .pipe_advance   (pipe_advance),
    .pipe_valid_out (pipe_valid_out),
    .fifo_wr        (fifo_wr),
    .fifo_rd        (fifo_rd),
    .inflight       (inflight),
    .occupancy      (occupancy),
    .state          (state),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural pipeline: valid bits shift one stage per advancing cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pipe_sr <= '0;
    else if (pipe_advance) pipe_sr <= {pipe_sr[S-2:0], pipe_valid_in};
  end

  assign pipe_valid_out = use_model ? pipe_sr[S-1] : pvo_drv;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    enable   = 1'b0;
    hold     = 1'b0;
    in_valid = 1'b0;
    fifo_rd  = 1'b0;
    pvo_drv  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en, hld, iv, pvo, rd;
    logic [1:0] st;
    logic       ir, adv, wr;
    int         infl, occ;
    logic       er;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int admits, wrs, first_admit, first_wr, viol, cyc;
    bit done;

    //            en hd iv pv rd  st ir ad wr inf occ er
    vecs[0]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0};
    vecs[4]  = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 2, 0, 0};
    vecs[5]  = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0};
    vecs[6]  = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 2, 0};
    vecs[7]  = '{1, 1, 1, 1, 0, 2, 0, 0, 0, 2, 1, 0};
    vecs[8]  = '{1, 0, 0, 0, 1, 2, 0, 0, 0, 2, 1, 0};
    vecs[9]  = '{0, 1, 1, 1, 0, 1, 1, 1, 1, 2, 0, 0};
    vecs[10] = '{1, 0, 1, 1, 0, 3, 0, 1, 1, 2, 1, 0};
    vecs[11] = '{0, 0, 0, 1, 0, 3, 0, 1, 1, 1, 2, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 3, 0};
    vecs[13] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3, 0};
    vecs[14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0};
    vecs[15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    vecs[16] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[18] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[19] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 1};
    vecs[20] = '{1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1};

    use_model = 1'b0;
    do_reset();

    // Reset state.
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_inflight", inflight, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_advance", pipe_advance, 0);

    // Directed vector table with manually driven pipe_valid_out.
    for (int i = 0; i < 21; i++) begin
      next_cycle();
      enable = vecs[i].en; hold = vecs[i].hld; in_valid = vecs[i].iv;
      pvo_drv = vecs[i].pvo; fifo_rd = vecs[i].rd;
      @(negedge clk);
      check($sformatf("v%0d_state", i), state, vecs[i].st);
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].ir);
      check($sformatf("v%0d_pipe_valid_in", i), pipe_valid_in, vecs[i].ir & vecs[i].iv);
      check($sformatf("v%0d_advance", i), pipe_advance, vecs[i].adv);
      check($sformatf("v%0d_fifo_wr", i), fifo_wr, vecs[i].wr);
      check($sformatf("v%0d_inflight", i), inflight, vecs[i].infl);
      check($sformatf("v%0d_occupancy", i), occupancy, vecs[i].occ);
      check($sformatf("v%0d_err", i), err, vecs[i].er);
    end

    // Fill: continuous input, no reads.
    use_model = 1'b1;
    do_reset();
    enable = 1'b1; in_valid = 1'b1;
    admits = 0; wrs = 0; first_admit = -1; first_wr = -1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (in_ready && in_valid) begin
        admits++;
        if (first_admit < 0) first_admit = c;
      end
      if (fifo_wr) begin
        wrs++;
        if (first_wr < 0) first_wr = c;
      end
      next_cycle();
    end
    @(negedge clk);
    check("fill_admits", admits, D);
    check("fill_writes", wrs, D);
    check("fill_latency", first_wr - first_admit, S);
    check("fill_occupancy", occupancy, D);
    check("fill_inflight", inflight, 0);
    check("fill_in_ready", in_ready, 0);
    check("fill_err", err, 0);

    // Steady state: read every cycle from a full FIFO.
    next_cycle();
    fifo_rd = 1'b1;
    admits = 0; viol = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 0) check("full_in_ready_blocked", in_ready, 0);
      if (c == 1) check("credit_resume", in_ready, 1);
      if (c >= 40 && in_ready && in_valid) admits++;
      if (int'(occupancy) + int'(inflight) > D) viol++;
      next_cycle();
    end
    check("steady_admits", admits, 40);
    check("credit_violations", viol, 0);
    check("steady_err", err, 0);

    // Hold with five words in flight.
    do_reset();
    enable = 1'b1;
    admits = 0;
    for (int c = 0; c < 20 && admits < 5; c++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready && in_valid) admits++;
      next_cycle();
    end
    in_valid = 1'b0;
    check("hold_setup_admits", admits, 5);
    hold = 1'b1;
    @(negedge clk);
    next_cycle();
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_state", state, 2);
      check("hold_advance", pipe_advance, 0);
      check("hold_in_ready", in_ready, 0);
      check("hold_fifo_wr", fifo_wr, 0);
      check("hold_inflight", inflight, 5);
      next_cycle();
    end
    hold = 1'b0; in_valid = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (occupancy == CW'(5)) done = 1'b1;
      next_cycle();
    end
    @(negedge clk);
    check("hold_resume_occupancy", occupancy, 5);
    check("hold_resume_inflight", inflight, 0);

    // Drain with seven words in flight.
    next_cycle();
    admits = 0;
    for (int c = 0; c < 20 && admits < 7; c++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready && in_valid) admits++;
      next_cycle();
    end
    check("drain_setup_admits", admits, 7);
    enable = 1'b0; in_valid = 1'b0;
    wrs = 0; viol = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (fifo_wr) wrs++;
      if (state == 2'd3 && in_ready) viol++;
      if (state == 2'd0) done = 1'b1;
      next_cycle();
      in_valid = 1'b1;
    end
    check("drain_reached_idle", done, 1);
    check("drain_writes", wrs, 7);
    check("drain_in_ready_leak", viol, 0);
    @(negedge clk);
    check("drain_inflight", inflight, 0);
    check("drain_occupancy", occupancy, 12);
    check("drain_in_ready", in_ready, 0);

    // Read from an empty FIFO sets a sticky error.
    do_reset();
    fifo_rd = 1'b1;
    next_cycle();
    fifo_rd = 1'b0;
    @(negedge clk);
    check("underflow_occupancy", occupancy, 0);
    check("underflow_err", err, 1);
    repeat (5) next_cycle();
    @(negedge clk);
    check("underflow_err_sticky", err, 1);
    do_reset();
    @(negedge clk);
    check("err_cleared_by_reset", err, 0);

    // Asynchronous reset between clock edges while running.
    enable = 1'b1; in_valid = 1'b1;
    cyc = 0;
    repeat (20) next_cycle();
    @(negedge clk);
    check("pre_async_state", state, 1);
    #2 reset = 1'b0;
    #1;
    check("async_state", state, 0);
    check("async_in_ready", in_ready, 0);
    check("async_pipe_valid_in", pipe_valid_in, 0);
    check("async_advance", pipe_advance, 0);
    check("async_fifo_wr", fifo_wr, 0);
    check("async_inflight", inflight, 0);
    check("async_occupancy", occupancy, 0);
    check("async_err", err, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post_release_state", state, 0);
    next_cycle();
    @(negedge clk);
    check("first_edge_state", state, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
